// File: rtl/hilo_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_ctrl
//
// Sequencer and HI/LO register file between the control unit and the
// multiply/divide units. A one-cycle op_start launches a multiply or divide.
// The selected unit's control line then stays high until that unit raises its
// done flag. On that edge the 64-bit result is captured into the
// architectural HI/LO registers. A divide-by-zero retire leaves HI/LO
// untouched and raises div0_exc. mthi/mtlo write HI/LO directly while idle.
//
// Optional feature macro: HILO_TIMEOUT_EN
//   When defined, an 8-bit wait counter aborts an operation whose unit has
//   not finished after TIMEOUT cycles, and sets a sticky timeout flag.
//   When undefined, the sequencer waits indefinitely and timeout is tied 0.
//
// Parameters
//   DATA_W   operand / HI / LO width
//   TIMEOUT  cycles to wait for a unit before aborting (1..256, timeout build)
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-low reset
//   op_start   one-cycle launch request (IDLE only)
//   op_div     with op_start: 1 = divide, 0 = multiply
//   mthi/mtlo  write wdata to HI / LO (IDLE only, dropped if op_start)
//   wdata      data for mthi/mtlo
//   mult_ctrl  start/hold level to the multiplier
//   mult_stop  multiplier done flag
//   mult_hi/lo multiplier result words
//   div_ctrl   start/hold level to the divider
//   div_done   divider done flag
//   div0       divider divide-by-zero flag
//   div_hi/lo  remainder / quotient
//   hi, lo     architectural HI / LO
//   busy       operation in flight (state != IDLE)
//   done       one-cycle retire pulse (normal, div0 or timeout)
//   div0_exc   one-cycle pulse with done on divide-by-zero retire
//   timeout    sticky abort flag, cleared only by reset
// ---------------------------------------------------------------------------
module hilo_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_start,
    input  logic              op_div,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [DATA_W-1:0] wdata,
    output logic              mult_ctrl,
    input  logic              mult_stop,
    input  logic [DATA_W-1:0] mult_hi,
    input  logic [DATA_W-1:0] mult_lo,
    output logic              div_ctrl,
    input  logic              div_done,
    input  logic              div0,
    input  logic [DATA_W-1:0] div_hi,
    input  logic [DATA_W-1:0] div_lo,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              div0_exc,
    output logic              timeout
);

    typedef enum logic [1:0] {
        IDLE,
        M_WAIT,
        D_WAIT,
        COOL
    } state_t;

    state_t state;

    // Any non-idle state means the control unit must stall.
    assign busy = (state != IDLE);

`ifdef HILO_TIMEOUT_EN
    // The counter is zero in the first wait cycle, so it equals TIMEOUT-1 in
    // the TIMEOUT-th wait cycle; aborting on that edge makes done visible one
    // cycle after the last permitted wait cycle.
    logic [7:0] wait_cnt;
    logic       wait_expired;

    assign wait_expired = (wait_cnt == 8'(TIMEOUT - 1));
`else
    // TIMEOUT has no effect without the timeout feature.
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT;
    assign timeout            = 1'b0;
`endif

    // Sequencer and HI/LO register file. All outputs apart from busy are
    // registered here. The ctrl lines are cleared on the edge that leaves a
    // wait state, so COOL always shows both units a low level before any
    // restart. done/div0_exc default low so they can only pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            hi        <= '0;
            lo        <= '0;
            mult_ctrl <= 1'b0;
            div_ctrl  <= 1'b0;
            done      <= 1'b0;
            div0_exc  <= 1'b0;
`ifdef HILO_TIMEOUT_EN
            timeout   <= 1'b0;
            wait_cnt  <= '0;
`endif
        end else begin
            done     <= 1'b0;
            div0_exc <= 1'b0;
`ifdef HILO_TIMEOUT_EN
            wait_cnt <= wait_cnt + 8'd1;
`endif
            case (state)
                IDLE: begin
                    // A launch request takes precedence and drops any write
                    // presented in the same cycle.
                    if (op_start) begin
`ifdef HILO_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                        if (op_div) begin
                            state    <= D_WAIT;
                            div_ctrl <= 1'b1;
                        end else begin
                            state     <= M_WAIT;
                            mult_ctrl <= 1'b1;
                        end
                    end else begin
                        if (mthi) begin
                            hi <= wdata;
                        end
                        if (mtlo) begin
                            lo <= wdata;
                        end
                    end
                end

                M_WAIT: begin
                    // The unit's done flag wins over an expiry in the same cycle.
                    if (mult_stop) begin
                        hi        <= mult_hi;
                        lo        <= mult_lo;
                        done      <= 1'b1;
                        mult_ctrl <= 1'b0;
                        state     <= COOL;
                    end
`ifdef HILO_TIMEOUT_EN
                    else if (wait_expired) begin
                        done      <= 1'b1;
                        timeout   <= 1'b1;
                        mult_ctrl <= 1'b0;
                        state     <= COOL;
                    end
`endif
                end

                D_WAIT: begin
                    // A divide by zero retires without touching HI/LO.
                    if (div_done) begin
                        if (div0) begin
                            div0_exc <= 1'b1;
                        end else begin
                            hi <= div_hi;
                            lo <= div_lo;
                        end
                        done     <= 1'b1;
                        div_ctrl <= 1'b0;
                        state    <= COOL;
                    end
`ifdef HILO_TIMEOUT_EN
                    else if (wait_expired) begin
                        done     <= 1'b1;
                        timeout  <= 1'b1;
                        div_ctrl <= 1'b0;
                        state    <= COOL;
                    end
`endif
                end

                COOL: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hilo_ctrl
//
// Scoreboard bench for hilo_ctrl. Each launched operation pushes its expected
// retire values (HI, LO, div0_exc, timeout) computed from a small HI/LO model.
// A negedge monitor pops one entry per done pulse. The mult/div units are
// stubbed inline by the stimulus task. The stub injects stray done flags and
// requests while busy, and the bench checks that they are ignored.
// ---------------------------------------------------------------------------
module tb_hilo_ctrl;

    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 64;

    logic              clk;
    logic              reset;
    logic              op_start;
    logic              op_div;
    logic              mthi;
    logic              mtlo;
    logic [DATA_W-1:0] wdata;
    logic              mult_ctrl;
    logic              mult_stop;
    logic [DATA_W-1:0] mult_hi;
    logic [DATA_W-1:0] mult_lo;
    logic              div_ctrl;
    logic              div_done;
    logic              div0;
    logic [DATA_W-1:0] div_hi;
    logic [DATA_W-1:0] div_lo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              busy;
    logic              done;
    logic              div0_exc;
    logic              timeout;

    typedef struct {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic              div0;
        logic              tmo;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] model_hi;
    logic [DATA_W-1:0] model_lo;
    logic              done_prev;
    int                n_checks;
    int                n_fail;

    hilo_ctrl #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .op_start  (op_start),
        .op_div    (op_div),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .wdata     (wdata),
        .mult_ctrl (mult_ctrl),
        .mult_stop (mult_stop),
        .mult_hi   (mult_hi),
        .mult_lo   (mult_lo),
        .div_ctrl  (div_ctrl),
        .div_done  (div_done),
        .div0      (div0),
        .div_hi    (div_hi),
        .div_lo    (div_lo),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .div0_exc  (div0_exc),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: every cycle out of reset, the ctrl lines must be exclusive,
    // done must be a single-cycle pulse, and div0_exc must accompany done.
    // Each done pulse retires the oldest scoreboard entry.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            checkOutput("ctrl_exclusive", 64'(mult_ctrl & div_ctrl), 64'd0);
            checkOutput("done_one_cycle", 64'(done & done_prev), 64'd0);
            checkOutput("exc_needs_done", 64'(div0_exc & ~done), 64'd0);
            if (done === 1'b1) begin
                checkOutput("sb_pending", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("sb_hi", 64'(hi), 64'(e.hi));
                    checkOutput("sb_lo", 64'(lo), 64'(e.lo));
                    checkOutput("sb_div0_exc", 64'(div0_exc), 64'(e.div0));
                    checkOutput("sb_timeout", 64'(timeout), 64'(e.tmo));
                end
            end
        end
        done_prev = (reset === 1'b1) ? done : 1'b0;
    end

    task automatic clearInputs();
        op_start  = 1'b0;
        op_div    = 1'b0;
        mthi      = 1'b0;
        mtlo      = 1'b0;
        wdata     = '0;
        mult_stop = 1'b0;
        mult_hi   = '0;
        mult_lo   = '0;
        div_done  = 1'b0;
        div0      = 1'b0;
        div_hi    = '0;
        div_lo    = '0;
    endtask

    // mthi/mtlo write while idle; the value is visible the next cycle.
    task automatic writeHiLo(input bit wr_hi, input bit wr_lo, input logic [DATA_W-1:0] data);
        @(posedge clk); #1;
        mthi  = wr_hi;
        mtlo  = wr_lo;
        wdata = data;
        @(posedge clk); #1;
        mthi = 1'b0;
        mtlo = 1'b0;
        if (wr_hi) model_hi = data;
        if (wr_lo) model_lo = data;
        @(negedge clk);
        checkOutput("wr_hi", 64'(hi), 64'(model_hi));
        checkOutput("wr_lo", 64'(lo), 64'(model_lo));
    endtask

    // Launches one operation and plays the unit stub. op_start is in cycle 0
    // and the unit's done flag is raised in cycle lat (never, if stall), so
    // the ctrl line must be high for cycles 1..lat and done must appear in
    // cycle lat+1. In cycle 3 the task injects a stray done from the other
    // unit, a new request and HI/LO writes, all of which must be ignored.
    task automatic applyStimulus(input bit is_div, input int lat,
                                 input logic [DATA_W-1:0] res_hi,
                                 input logic [DATA_W-1:0] res_lo,
                                 input bit zero, input bit stall, input bit also_mtlo);
        exp_t e;
        bit   noise;
        @(posedge clk); #1;
        op_start = 1'b1;
        op_div   = is_div;
        mtlo     = also_mtlo;
        wdata    = 32'h0000_9999;
        e.hi   = (zero || stall) ? model_hi : res_hi;
        e.lo   = (zero || stall) ? model_lo : res_lo;
        e.div0 = zero && !stall;
        e.tmo  = stall;
        sb.push_back(e);
        @(posedge clk); #1;
        for (int i = 1; i <= lat; i++) begin
            noise    = (i == 3) && (i < lat);
            op_start = noise;
            op_div   = !is_div;
            mthi     = noise;
            mtlo     = noise;
            wdata    = 32'hBAD0_BAD0;
            if (is_div) begin
                div_done  = (i == lat) && !stall;
                div0      = zero;
                div_hi    = res_hi;
                div_lo    = res_lo;
                mult_stop = noise;
                mult_hi   = '1;
                mult_lo   = '1;
            end else begin
                mult_stop = (i == lat) && !stall;
                mult_hi   = res_hi;
                mult_lo   = res_lo;
                div_done  = noise;
                div0      = noise;
                div_hi    = '1;
                div_lo    = '1;
            end
            @(negedge clk);
            checkOutput(is_div ? "div_ctrl_hold" : "mult_ctrl_hold",
                        64'(is_div ? div_ctrl : mult_ctrl), 64'd1);
            checkOutput("busy_wait", 64'(busy), 64'd1);
            checkOutput("hi_hold", 64'(hi), 64'(model_hi));
            checkOutput("lo_hold", 64'(lo), 64'(model_lo));
            checkOutput("no_early_done", 64'(done), 64'd0);
            @(posedge clk); #1;
        end
        clearInputs();
        if (!zero && !stall) begin
            model_hi = res_hi;
            model_lo = res_lo;
        end
        @(negedge clk);
        checkOutput("done_at_retire", 64'(done), 64'd1);
        checkOutput("cool_ctrl_low", 64'(mult_ctrl | div_ctrl), 64'd0);
        checkOutput("cool_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("idle_busy", 64'(busy), 64'd0);
        checkOutput("idle_done", 64'(done), 64'd0);
        checkOutput("idle_hi", 64'(hi), 64'(model_hi));
        checkOutput("idle_lo", 64'(lo), 64'(model_lo));
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        done_prev = 1'b0;
        model_hi  = '0;
        model_lo  = '0;
        reset     = 1'b0;
        clearInputs();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst_hi", 64'(hi), 64'd0);
        checkOutput("rst_lo", 64'(lo), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_ctrl", 64'({mult_ctrl, div_ctrl}), 64'd0);
        checkOutput("rst_div0_exc", 64'(div0_exc), 64'd0);
        checkOutput("rst_timeout", 64'(timeout), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        $display("[TB] mult 6*7, unit finishes after 33 cycles");
        applyStimulus(1'b0, 33, 32'd0, 32'd42, 1'b0, 1'b0, 1'b0);

        $display("[TB] div 23/7");
        applyStimulus(1'b1, 10, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);

        $display("[TB] simultaneous mthi+mtlo");
        writeHiLo(1'b1, 1'b1, 32'h0000_0077);

        $display("[TB] div 10/0 after preload");
        writeHiLo(1'b1, 1'b0, 32'h0000_AAAA);
        writeHiLo(1'b0, 1'b1, 32'h0000_5555);
        applyStimulus(1'b1, 5, 32'hDEAD_0000, 32'h0000_BEEF, 1'b1, 1'b0, 1'b0);

        $display("[TB] mthi then op_start with mtlo in the same cycle");
        writeHiLo(1'b1, 1'b0, 32'h0000_1234);
        applyStimulus(1'b0, 4, 32'd5, 32'd6, 1'b0, 1'b0, 1'b1);

        $display("[TB] reset during divide wait");
        @(posedge clk); #1;
        op_start = 1'b1;
        op_div   = 1'b1;
        @(posedge clk); #1;
        op_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("pre_rst_div_ctrl", 64'(div_ctrl), 64'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset    = 1'b1;
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        checkOutput("midrst_div_ctrl", 64'(div_ctrl), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_done", 64'(done), 64'd0);
        checkOutput("midrst_hi", 64'(hi), 64'd0);
        checkOutput("midrst_lo", 64'(lo), 64'd0);
        @(posedge clk); #1;
        div_done = 1'b1;
        div_hi   = 32'h1111_1111;
        div_lo   = 32'h2222_2222;
        @(posedge clk); #1;
        clearInputs();
        @(negedge clk);
        checkOutput("idle_done_ignored", 64'(done), 64'd0);
        checkOutput("idle_hi_ignored", 64'(hi), 64'd0);
        checkOutput("idle_lo_ignored", 64'(lo), 64'd0);

`ifdef HILO_TIMEOUT_EN
        $display("[TB] mult unit never finishes");
        writeHiLo(1'b1, 1'b1, 32'h0000_0C0C);
        applyStimulus(1'b0, TIMEOUT, 32'd7, 32'd8, 1'b0, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("timeout_sticky", 64'(timeout), 64'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("timeout_cleared", 64'(timeout), 64'd0);
`else
        @(negedge clk);
        checkOutput("timeout_tied", 64'(timeout), 64'd0);
`endif

        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
